btn_debounce: RTL and testbench

- Conditions raw Nexys4 pushbuttons/switches into clean robot drive inputs.
- Synchronizes each raw input, filters contact bounce, and outputs stable levels that drive the RojoBot wheel controls left_fwd, left_rev, right_fwd and right_rev.
- Also outputs one-cycle rise/fall pulses per channel for edge-triggered consumers such as mode select.
- Sits directly upstream of the robot core, in the same clock domain.

---
 rtl/btn_debounce.sv | 55 +++++
 tb/tb_btn_debounce.sv | 124 ++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer, per-channel stability filter and registered edge pulses
module btn_debounce #(
   parameter int CLK_FREQUENCY_HZ      = 100000000,
   parameter int DEBOUNCE_MS           = 10,
   parameter int NUM_CH                = 6,
   parameter int CNTR_WIDTH            = 32,
   parameter bit SIMULATE              = 1'b0,
   parameter int SIMULATE_DEBOUNCE_CNT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] raw_in,
   output logic [NUM_CH-1:0] db_out,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse
);
   localparam logic [CNTR_WIDTH-1:0] TOP = SIMULATE ? CNTR_WIDTH'(SIMULATE_DEBOUNCE_CNT)
                                                    : CNTR_WIDTH'(CLK_FREQUENCY_HZ / 1000 * DEBOUNCE_MS - 1);
   localparam logic [CNTR_WIDTH-1:0] ONE = 1;
   logic [NUM_CH-1:0]     sync1_q, sync2_q, db_q, db_d, rise_q, rise_d, fall_q, fall_d, hit;
   logic [CNTR_WIDTH-1:0] cnt_q [NUM_CH];
   logic [CNTR_WIDTH-1:0] cnt_d [NUM_CH];
   // per channel: count while the synchronized input disagrees with the output, flip at TOP
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i]   = (sync2_q[i] != db_q[i]) && (cnt_q[i] == TOP);
         cnt_d[i] = (sync2_q[i] == db_q[i] || hit[i]) ? '0 : cnt_q[i] + ONE;
      end
      db_d   = db_q ^ hit;
      rise_d = hit & sync2_q;
      fall_d = hit & ~sync2_q;
   end
   // all state, including the synchronizer, clears asynchronously on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         cnt_q   <= '{default: '0};
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end
   assign db_out     = db_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: vector table, hand sequences and random stimulus against a history-window model
module tb_btn_debounce;
   localparam int TOP = 3;
   logic       clk = 1'b0, reset = 1'b0;
   logic [5:0] raw_in = '0, db_out, rise_pulse, fall_pulse;
   int         errors = 0, checks = 0;
   typedef struct {logic [5:0] raw, db, rise, fall;} vec_t;
   vec_t       tbl[$];
   logic [5:0] hist [TOP+2];
   logic [5:0] m_db, m_rise, m_fall, diff, mask;

   always #5 clk = ~clk;

   btn_debounce #(.NUM_CH(6), .SIMULATE(1'b1), .SIMULATE_DEBOUNCE_CNT(TOP)) dut (
      .clk(clk), .reset(reset), .raw_in(raw_in),
      .db_out(db_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse));

   // reference: a bit flips when the last TOP+1 values seen after the two-stage delay all differ from it
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < TOP + 2; k++) hist[k] = '0;
         m_db = '0; m_rise = '0; m_fall = '0;
      end else begin
         diff = '1;
         for (int k = 1; k <= TOP + 1; k++) diff &= hist[k] ^ m_db;
         m_rise = diff & ~m_db;
         m_fall = diff & m_db;
         m_db   = m_db ^ diff;
         for (int k = TOP + 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = raw_in;
      end
   end

   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clean_reset();
      reset = 1'b0; raw_in = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      for (int j = 0; j < 8; j++)
         tbl.push_back('{raw: 6'h01, db: (j >= 5) ? 6'h01 : 6'h00, rise: (j == 5) ? 6'h01 : 6'h00, fall: 6'h00});
      for (int j = 0; j < 12; j++)
         tbl.push_back('{raw: (j == 3) ? 6'h01 : 6'h05, db: (j >= 9) ? 6'h05 : 6'h01, rise: (j == 9) ? 6'h04 : 6'h00, fall: 6'h00});
      for (int j = 0; j < 8; j++)
         tbl.push_back('{raw: 6'h04, db: (j >= 5) ? 6'h04 : 6'h05, rise: 6'h00, fall: (j == 5) ? 6'h01 : 6'h00});

      // asynchronous reset clears outputs without a clock edge, then all channels rise together
      repeat (2) @(negedge clk);
      reset = 1'b1; raw_in = 6'h3F;
      repeat (8) @(negedge clk);
      chk("pre_reset_db", db_out, 6'h3F);
      #2 reset = 1'b0;
      #1;
      chk("async_db", db_out, 6'h00);
      chk("async_rise", rise_pulse, 6'h00);
      chk("async_fall", fall_pulse, 6'h00);
      @(negedge clk);
      reset = 1'b1;
      for (int j = 0; j < 7; j++) begin
         @(negedge clk);
         chk("rel_db", db_out, (j >= 5) ? 6'h3F : 6'h00);
         chk("rel_rise", rise_pulse, (j == 5) ? 6'h3F : 6'h00);
      end

      // press, bounce and release vectors
      clean_reset();
      foreach (tbl[n]) begin
         raw_in = tbl[n].raw;
         @(negedge clk);
         chk("tbl_db", db_out, tbl[n].db);
         chk("tbl_rise", rise_pulse, tbl[n].rise);
         chk("tbl_fall", fall_pulse, tbl[n].fall);
      end

      // channels 3,4 rise together, channel 5 two cycles later
      for (int j = 0; j < 10; j++) begin
         raw_in = (j >= 2) ? 6'h3C : 6'h1C;
         @(negedge clk);
         chk("sim_db", db_out, 6'h04 | ((j >= 5) ? 6'h18 : 6'h00) | ((j >= 7) ? 6'h20 : 6'h00));
         chk("sim_rise", rise_pulse, ((j == 5) ? 6'h18 : 6'h00) | ((j == 7) ? 6'h20 : 6'h00));
         chk("sim_fall", fall_pulse, 6'h00);
      end

      // reset in the middle of a pending count discards it
      clean_reset();
      raw_in = 6'h01;
      repeat (3) @(negedge clk);
      chk("mid_pre_db", db_out, 6'h00);
      #2 reset = 1'b0;
      #1 chk("mid_in_reset_db", db_out, 6'h00);
      @(negedge clk);
      reset = 1'b1;
      for (int j = 0; j < 7; j++) begin
         @(negedge clk);
         chk("mid_db", db_out, (j >= 5) ? 6'h01 : 6'h00);
         chk("mid_rise", rise_pulse, (j == 5) ? 6'h01 : 6'h00);
      end

      // random bouncing inputs against the model
      clean_reset();
      for (int n = 0; n < 3000; n++) begin
         mask = '0;
         for (int b = 0; b < 6; b++) mask[b] = ($urandom_range(0, 5) == 0);
         raw_in = raw_in ^ mask;
         @(negedge clk);
         chk("rnd_db", db_out, m_db);
         chk("rnd_rise", rise_pulse, m_rise);
         chk("rnd_fall", fall_pulse, m_fall);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
